pattern_buffer_sequencer: RTL and testbench
===========================================

Name: pattern_buffer_sequencer

Overview:
Controller for the 8-instance pattern buffer bank. It generates the one-hot buffer, field and write pointers, so the bank only ever sees legal one-hot selects. It sequences playback of the fields in a chosen buffer and arbitrates that against host field writes, which share the bank's bufp select. It also performs glitch-free buffer swaps on pattern boundaries.

Parameters:
buffer_size, 22, fields (bytes) per buffer
buffer_width, 8, bits per field
no_bufs, 8, buffer instances (one-hot select width)
FW, $clog2(buffer_size) = 5, field index width (localparam)
BW, $clog2(no_bufs) = 3, buffer index width (localparam)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
start  in  1  pulse: begin playback of play_buf from field 0
stop  in  1  pulse: finish the current read, then return to IDLE
play_len  in  FW  fields per pattern, legal range 1..buffer_size
play_buf  in  BW  buffer to play, sampled on start
swap_req  in  1  pulse: queue swap to swap_buf at the next pattern wrap
swap_buf  in  BW  target buffer for the swap
wr_req  in  1  host write request, held until wr_ack
wr_buf  in  BW  target buffer of the write
wr_field  in  FW  target field of the write
wr_data  in  buffer_width  write data
wr_ack  out  1  one-cycle grant/complete strobe
wr_err  out  1  one-cycle strobe: write rejected (wr_field >= buffer_size)
buffer_select  out  no_bufs  one-hot, registered, the buffer being played
bufp  out  no_bufs  one-hot bank select shared by read and write
fieldp  out  buffer_size  one-hot read field pointer
fieldwp  out  buffer_size  one-hot write field pointer
field_in  out  buffer_width  write data to the bank
field_write  out  1  bank write enable
field_byte  in  buffer_width  bank read data (combinational from bufp/fieldp)
pat_byte  out  buffer_width  registered playback byte
pat_valid  out  1  pat_byte valid strobe
pat_wrap  out  1  strobe with the last field of each pattern
busy  out  1  high outside IDLE

Behaviour:
- Reset (async, immediate):
  - buffer_select = bufp = 1 (bit 0).
  - fieldp = fieldwp = 1 (bit 0); one-hot invariant holds at all times, the all-zero value is never driven.
  - field_in = 0; field_write, wr_ack, wr_err, pat_valid, pat_wrap, busy = 0; FSM = IDLE; the swap queue is cleared.
- FSM states: IDLE, PLAY, WRITE.
  - IDLE: busy=0.
    - start with 1 <= play_len <= buffer_size: load buffer_select/bufp from play_buf, field index 0 -> PLAY.
    - start with an illegal play_len is ignored.
    - If wr_req is pending (and start is not taking the transition to PLAY) -> WRITE.
  - PLAY: each cycle is a read slot. bufp = buffer_select, fieldp = current index; field_byte is registered into pat_byte with pat_valid=1 one cycle later (latency 1).
    - Index increments; at index play_len-1, pat_wrap is asserted alongside that byte and the index wraps to 0.
  - WRITE (one cycle): bufp = onehot(wr_buf), fieldwp = onehot(wr_field), field_in = wr_data, field_write = 1, wr_ack = 1.
    - Return to PLAY (index unchanged, no pat_valid for that slot) if playback is active, else IDLE.
- Arbitration: a pending write is granted only when the previous cycle was a read slot; playback is never starved for more than 1 cycle in 2. In IDLE, a write is granted immediately.
- Write to the buffer currently playing is allowed and takes effect on subsequent reads of that field.
- wr_field >= buffer_size: no field_write; wr_ack and wr_err pulse together in the grant cycle.
- field_write is only ever asserted in WRITE, so read slots never write.
- Swap: swap_req latches swap_buf (a later swap_req overwrites it). At the pattern wrap edge, buffer_select/bufp load the queued buffer and the queue clears.
  - swap_req in IDLE applies to buffer_select immediately.
  - swap_req coincident with the wrap cycle applies at the next wrap.
- stop: the current read slot completes, then -> IDLE. A write granted in the same cycle still completes. start and stop together: stop wins.
- start while in PLAY restarts at field 0 of play_buf, with no pat_wrap.
- play_len is sampled on start only.
- Async reset mid-write drops field_write immediately; wr_req stays un-acked.

Decomposition:
- Shared package pattern_pkg: buffer_size, buffer_width, no_bufs, FW, BW, and the FSM state enum.
- Sub-module onehot_ring: a one-hot pointer with load(index), advance, and wrap-at-limit ports. It is used for the field read pointer; the bank selects are decoded from index with a shared function in pattern_pkg.

Test Plan:
- Reset -> buffer_select=8'h01, bufp=8'h01, fieldp=22'h1, field_write=0, busy=0; fieldp/bufp checked one-hot every cycle thereafter.
- Buffer 3 preloaded fields 0..4 = A0..A4; start, play_buf=3, play_len=5 -> pat_byte A0..A4, A0.. on consecutive cycles; pat_wrap with A4; bufp=8'h08.
- Continuous wr_req to buf 6, field 2, data 5A during PLAY -> reads and writes alternate; field_write with bufp=8'h40, fieldwp bit 2; playback gap of exactly 1 cycle per write.
- swap_req, swap_buf=1 mid-pattern -> buffer_select changes to 8'h02 only on the cycle after pat_wrap; no partial pattern from buffer 1.
- wr_field=22 -> wr_ack and wr_err together, field_write never asserted.
- start with play_len=0 -> stays IDLE; stop and start in the same cycle -> IDLE; rst asserted mid-WRITE -> field_write low without waiting for a clock edge.

Source files
------------

// File: rtl/pattern_pkg.sv
// Shared constants, FSM state type and one-hot decode helpers for the
// pattern buffer bank controller.
package pattern_pkg;

   localparam int buffer_size  = 22;
   localparam int buffer_width = 8;
   localparam int no_bufs      = 8;
   localparam int FW           = $clog2(buffer_size);
   localparam int BW           = $clog2(no_bufs);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PLAY  = 2'd1,
      ST_WRITE = 2'd2
   } state_t;

   // Buffer index to one-hot bank select; every BW-bit index is legal.
   function automatic logic [no_bufs-1:0] onehot_buf(input logic [BW-1:0] idx);
      onehot_buf      = '0;
      onehot_buf[idx] = 1'b1;
   endfunction

   // Field index to one-hot field select. Out-of-range indices give zero,
   // so callers only use it on indices already known to be legal.
   function automatic logic [buffer_size-1:0] onehot_field(input logic [FW-1:0] idx);
      onehot_field = '0;
      for (int i = 0; i < buffer_size; i++) begin
         onehot_field[i] = (int'(idx) == i);
      end
   endfunction

endpackage

// File: rtl/onehot_ring.sv
// One-hot field pointer with a binary shadow index. Load has priority over
// advance; advancing from index limit-1 wraps back to field 0.
module onehot_ring
   import pattern_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   load,
   input  logic [FW-1:0]          load_idx,
   input  logic                   advance,
   input  logic [FW-1:0]          limit,
   output logic [buffer_size-1:0] ptr,
   output logic                   at_limit
);

   logic [FW-1:0]          idx_reg;
   logic [buffer_size-1:0] ptr_reg;

   assign at_limit = (idx_reg == (limit - 1'b1));
   assign ptr      = ptr_reg;

   // Pointer register: reset to field 0, load, or step/wrap around the pattern.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_reg <= '0;
         ptr_reg <= {{(buffer_size-1){1'b0}}, 1'b1};
      end else if (load) begin
         idx_reg <= load_idx;
         ptr_reg <= onehot_field(load_idx);
      end else if (advance) begin
         if (at_limit) begin
            idx_reg <= '0;
            ptr_reg <= {{(buffer_size-1){1'b0}}, 1'b1};
         end else begin
            idx_reg <= idx_reg + 1'b1;
            ptr_reg <= {ptr_reg[buffer_size-2:0], 1'b0};
         end
      end
   end

endmodule

// File: rtl/pattern_buffer_sequencer.sv
// Playback sequencer for the 8-instance pattern buffer bank. Interleaves
// read slots with host writes on the shared bufp select and swaps the
// playing buffer only on pattern boundaries.
module pattern_buffer_sequencer
   import pattern_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic                    stop,
   input  logic [FW-1:0]           play_len,
   input  logic [BW-1:0]           play_buf,
   input  logic                    swap_req,
   input  logic [BW-1:0]           swap_buf,
   input  logic                    wr_req,
   input  logic [BW-1:0]           wr_buf,
   input  logic [FW-1:0]           wr_field,
   input  logic [buffer_width-1:0] wr_data,
   output logic                    wr_ack,
   output logic                    wr_err,
   output logic [no_bufs-1:0]      buffer_select,
   output logic [no_bufs-1:0]      bufp,
   output logic [buffer_size-1:0]  fieldp,
   output logic [buffer_size-1:0]  fieldwp,
   output logic [buffer_width-1:0] field_in,
   output logic                    field_write,
   input  logic [buffer_width-1:0] field_byte,
   output logic [buffer_width-1:0] pat_byte,
   output logic                    pat_valid,
   output logic                    pat_wrap,
   output logic                    busy
);

   state_t                  state_reg, state_next;
   logic                    play_active_reg, play_active_next;
   logic [FW-1:0]           len_reg, len_next;
   logic [no_bufs-1:0]      buffer_select_reg, buffer_select_next;
   logic                    swap_pend_reg, swap_pend_next;
   logic [BW-1:0]           swap_buf_reg, swap_buf_next;
   logic [no_bufs-1:0]      wr_bufp_reg;
   logic [buffer_size-1:0]  fieldwp_reg;
   logic [buffer_width-1:0] field_in_reg;
   logic                    wr_bad_reg;
   logic [buffer_width-1:0] pat_byte_reg;
   logic                    pat_valid_reg, pat_wrap_reg;

   logic len_ok, wr_field_ok;
   logic read_slot, wrap_slot, load_play, grant;
   logic ring_load, ring_advance, ring_at_limit;
   logic [buffer_size-1:0] ring_ptr;

   assign len_ok      = (play_len != '0) && (play_len <= FW'(buffer_size));
   assign wr_field_ok = (wr_field < FW'(buffer_size));

   onehot_ring u_field_ring (
      .clk      (clk),
      .rst      (rst),
      .load     (ring_load),
      .load_idx ('0),
      .advance  (ring_advance),
      .limit    (len_reg),
      .ptr      (ring_ptr),
      .at_limit (ring_at_limit)
   );

   // Next-state, slot and grant decode. A write is granted either from IDLE
   // or out of a read slot, so WRITE never follows WRITE.
   always_comb begin
      state_next       = state_reg;
      play_active_next = play_active_reg;
      len_next         = len_reg;
      read_slot        = 1'b0;
      wrap_slot        = 1'b0;
      load_play        = 1'b0;
      grant            = 1'b0;
      ring_load        = 1'b0;
      ring_advance     = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (!stop && start && len_ok) begin
               load_play        = 1'b1;
               play_active_next = 1'b1;
               state_next       = ST_PLAY;
            end else if (wr_req) begin
               grant      = 1'b1;
               state_next = ST_WRITE;
            end
         end
         ST_PLAY: begin
            read_slot = 1'b1;
            if (stop) begin
               play_active_next = 1'b0;
            end else if (start && len_ok) begin
               load_play = 1'b1;
            end
            if (!load_play) begin
               ring_advance = 1'b1;
               wrap_slot    = ring_at_limit;
            end
            if (wr_req) begin
               grant      = 1'b1;
               state_next = ST_WRITE;
            end else if (stop) begin
               state_next = ST_IDLE;
            end
         end
         ST_WRITE: begin
            if (stop) begin
               play_active_next = 1'b0;
            end else if (start && len_ok) begin
               load_play        = 1'b1;
               play_active_next = 1'b1;
            end
            state_next = play_active_next ? ST_PLAY : ST_IDLE;
         end
         default: begin
            state_next       = ST_IDLE;
            play_active_next = 1'b0;
         end
      endcase
      if (load_play) begin
         ring_load = 1'b1;
         len_next  = play_len;
      end
   end

   // Buffer selection: start loads directly, a queued swap lands on the wrap
   // edge, and a swap while not playing takes effect at once.
   always_comb begin
      buffer_select_next = buffer_select_reg;
      swap_pend_next     = swap_pend_reg;
      swap_buf_next      = swap_buf_reg;
      if (wrap_slot && swap_pend_reg) begin
         buffer_select_next = onehot_buf(swap_buf_reg);
         swap_pend_next     = 1'b0;
      end
      if (swap_req) begin
         if (play_active_reg || load_play) begin
            swap_pend_next = 1'b1;
            swap_buf_next  = swap_buf;
         end else begin
            buffer_select_next = onehot_buf(swap_buf);
            swap_pend_next     = 1'b0;
         end
      end
      if (load_play) begin
         buffer_select_next = onehot_buf(play_buf);
      end
   end

   // Control state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg         <= ST_IDLE;
         play_active_reg   <= 1'b0;
         len_reg           <= FW'(1);
         buffer_select_reg <= {{(no_bufs-1){1'b0}}, 1'b1};
         swap_pend_reg     <= 1'b0;
         swap_buf_reg      <= '0;
      end else begin
         state_reg         <= state_next;
         play_active_reg   <= play_active_next;
         len_reg           <= len_next;
         buffer_select_reg <= buffer_select_next;
         swap_pend_reg     <= swap_pend_next;
         swap_buf_reg      <= swap_buf_next;
      end
   end

   // Capture the granted write; fieldwp keeps its last legal value so it
   // stays one-hot even when the write is rejected.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_bufp_reg  <= {{(no_bufs-1){1'b0}}, 1'b1};
         fieldwp_reg  <= {{(buffer_size-1){1'b0}}, 1'b1};
         field_in_reg <= '0;
         wr_bad_reg   <= 1'b0;
      end else if (grant) begin
         wr_bufp_reg  <= onehot_buf(wr_buf);
         field_in_reg <= wr_data;
         wr_bad_reg   <= !wr_field_ok;
         if (wr_field_ok) begin
            fieldwp_reg <= onehot_field(wr_field);
         end
      end
   end

   // Register the byte read in each slot, tagging the last field of a pattern.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pat_byte_reg  <= '0;
         pat_valid_reg <= 1'b0;
         pat_wrap_reg  <= 1'b0;
      end else begin
         pat_valid_reg <= read_slot;
         pat_wrap_reg  <= read_slot && wrap_slot;
         if (read_slot) begin
            pat_byte_reg <= field_byte;
         end
      end
   end

   // Write strobes decode straight from the state register so a reset drops
   // them without waiting for a clock edge.
   assign bufp          = (state_reg == ST_WRITE) ? wr_bufp_reg : buffer_select_reg;
   assign field_write   = (state_reg == ST_WRITE) && !wr_bad_reg;
   assign wr_ack        = (state_reg == ST_WRITE);
   assign wr_err        = (state_reg == ST_WRITE) && wr_bad_reg;
   assign busy          = (state_reg != ST_IDLE);
   assign buffer_select = buffer_select_reg;
   assign fieldp        = ring_ptr;
   assign fieldwp       = fieldwp_reg;
   assign field_in      = field_in_reg;
   assign pat_byte      = pat_byte_reg;
   assign pat_valid     = pat_valid_reg;
   assign pat_wrap      = pat_wrap_reg;

endmodule

// File: tb/tb_pattern_buffer_sequencer.sv
// Directed bench for pattern_buffer_sequencer with a behavioural bank model
// and a scoreboard queue of expected playback bytes.
module tb_pattern_buffer_sequencer;

   logic        clk;
   logic        rst;
   logic        start, stop;
   logic [4:0]  play_len;
   logic [2:0]  play_buf;
   logic        swap_req;
   logic [2:0]  swap_buf;
   logic        wr_req;
   logic [2:0]  wr_buf;
   logic [4:0]  wr_field;
   logic [7:0]  wr_data;
   logic        wr_ack, wr_err;
   logic [7:0]  buffer_select, bufp;
   logic [21:0] fieldp, fieldwp;
   logic [7:0]  field_in;
   logic        field_write;
   logic [7:0]  field_byte;
   logic [7:0]  pat_byte;
   logic        pat_valid, pat_wrap, busy;

   typedef struct {
      logic [7:0] b;
      logic       w;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;

   logic [7:0] mem [0:7][0:21];
   logic       pre_we;
   logic [2:0] pre_b;
   logic [4:0] pre_f;
   logic [7:0] pre_d;

   pattern_buffer_sequencer dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop),
      .play_len(play_len), .play_buf(play_buf),
      .swap_req(swap_req), .swap_buf(swap_buf),
      .wr_req(wr_req), .wr_buf(wr_buf), .wr_field(wr_field), .wr_data(wr_data),
      .wr_ack(wr_ack), .wr_err(wr_err),
      .buffer_select(buffer_select), .bufp(bufp),
      .fieldp(fieldp), .fieldwp(fieldwp),
      .field_in(field_in), .field_write(field_write), .field_byte(field_byte),
      .pat_byte(pat_byte), .pat_valid(pat_valid), .pat_wrap(pat_wrap), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [2:0] bidx(input logic [7:0] v);
      bidx = '0;
      for (int i = 0; i < 8; i++) if (v[i]) bidx = 3'(i);
   endfunction

   function automatic logic [4:0] fidx(input logic [21:0] v);
      fidx = '0;
      for (int i = 0; i < 22; i++) if (v[i]) fidx = 5'(i);
   endfunction

   // Bank model: combinational read, clocked write, plus a preload port.
   always @(posedge clk) begin
      if (pre_we) mem[pre_b][pre_f] <= pre_d;
      else if (field_write) mem[bidx(bufp)][fidx(fieldwp)] <= field_in;
   end
   always_comb field_byte = mem[bidx(bufp)][fidx(fieldp)];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic push(input logic [7:0] b, input logic w);
      exp_t e;
      e.b = b;
      e.w = w;
      sb_q.push_back(e);
   endtask

   task automatic preload(input logic [2:0] b, input logic [4:0] f, input logic [7:0] d);
      pre_b = b; pre_f = f; pre_d = d; pre_we = 1'b1;
      tick();
      pre_we = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && sb_q.size() != 0; i++) tick();
      chk("drain_empty", 32'(sb_q.size()), 32'd0);
   endtask

   // Monitor: one-hot invariants every cycle and scoreboard on playback output.
   always @(negedge clk) begin
      if (!rst) begin
         chk("fieldp_onehot", 32'($onehot(fieldp)), 32'd1);
         chk("bufp_onehot", 32'($onehot(bufp)), 32'd1);
         chk("fieldwp_onehot", 32'($onehot(fieldwp)), 32'd1);
         chk("bufsel_onehot", 32'($onehot(buffer_select)), 32'd1);
         if (pat_valid) begin
            if (sb_q.size() == 0) begin
               chk("unexpected_pat", 32'(pat_byte), 32'hFFFF_FFFF);
            end else begin
               mon_e = sb_q.pop_front();
               chk("pat_byte", 32'(pat_byte), 32'(mon_e.b));
               chk("pat_wrap", 32'(pat_wrap), 32'(mon_e.w));
            end
         end else begin
            chk("wrap_no_valid", 32'(pat_wrap), 32'd0);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; start = 0; stop = 0; play_len = 0; play_buf = 0;
      swap_req = 0; swap_buf = 0; wr_req = 0; wr_buf = 0; wr_field = 0; wr_data = 0;
      pre_we = 0; pre_b = 0; pre_f = 0; pre_d = 0;
      repeat (2) tick();
      for (int i = 0; i < 5; i++) preload(3'd3, 5'(i), 8'(8'hA0 + i));
      for (int i = 0; i < 5; i++) preload(3'd1, 5'(i), 8'(8'hB0 + i));
      for (int i = 0; i < 3; i++) preload(3'd6, 5'(i), 8'(8'h60 + i));
      for (int i = 0; i < 4; i++) preload(3'd5, 5'(i), 8'(8'h50 + i));

      // Reset values
      chk("rst_bufsel", 32'(buffer_select), 32'h01);
      chk("rst_bufp", 32'(bufp), 32'h01);
      chk("rst_fieldp", 32'(fieldp), 32'h1);
      chk("rst_fieldwp", 32'(fieldwp), 32'h1);
      chk("rst_field_write", 32'(field_write), 32'd0);
      chk("rst_field_in", 32'(field_in), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_wr_ack", 32'(wr_ack), 32'd0);
      chk("rst_pat_valid", 32'(pat_valid), 32'd0);
      rst = 1'b0;
      tick();

      // Plain playback of buffer 3, two full patterns of length 5
      play_buf = 3'd3; play_len = 5'd5; start = 1'b1;
      for (int r = 0; r < 10; r++) push(8'(8'hA0 + r % 5), (r % 5) == 4);
      tick(); start = 1'b0;
      chk("play_bufp", 32'(bufp), 32'h08);
      chk("play_fieldp0", 32'(fieldp), 32'h1);
      chk("play_busy", 32'(busy), 32'd1);
      repeat (2) tick();
      chk("play_fieldp2", 32'(fieldp), 32'h4);
      repeat (7) tick();
      stop = 1'b1; tick(); stop = 1'b0;
      drain();
      chk("stop_idle", 32'(busy), 32'd0);

      // Continuous write during playback: reads and writes alternate
      wr_buf = 3'd6; wr_field = 5'd2; wr_data = 8'h5A; wr_req = 1'b1;
      play_buf = 3'd3; play_len = 5'd5; start = 1'b1;
      for (int r = 0; r < 5; r++) push(8'(8'hA0 + r), r == 4);
      for (int k = 1; k <= 8; k++) begin
         tick();
         if (k == 1) begin
            start = 1'b0;
            chk("alt_read_bufp", 32'(bufp), 32'h08);
         end
         chk("alt_field_write", 32'(field_write), 32'(k % 2 == 0));
         chk("alt_pat_valid", 32'(pat_valid), 32'(k % 2 == 0));
         if (k == 2) begin
            chk("wr_bufp", 32'(bufp), 32'h40);
            chk("wr_fieldwp", 32'(fieldwp), 32'h4);
            chk("wr_field_in", 32'(field_in), 32'h5A);
            chk("wr_ack", 32'(wr_ack), 32'd1);
            chk("wr_err_clear", 32'(wr_err), 32'd0);
         end
         if (k == 8) wr_req = 1'b0;
      end
      tick();
      stop = 1'b1; tick(); stop = 1'b0;
      drain();

      // Read back buffer 6: field 2 now holds the written byte
      play_buf = 3'd6; play_len = 5'd3; start = 1'b1;
      push(8'h60, 1'b0); push(8'h61, 1'b0); push(8'h5A, 1'b1);
      tick(); start = 1'b0;
      repeat (2) tick();
      stop = 1'b1; tick(); stop = 1'b0;
      drain();

      // Swap to buffer 1 queued mid-pattern, lands on the wrap
      play_buf = 3'd3; play_len = 5'd5; start = 1'b1;
      for (int r = 0; r < 5; r++) push(8'(8'hA0 + r), r == 4);
      for (int r = 0; r < 5; r++) push(8'(8'hB0 + r), r == 4);
      tick(); start = 1'b0;
      tick(); swap_buf = 3'd1; swap_req = 1'b1;
      tick(); swap_req = 1'b0;
      chk("swap_pending_sel", 32'(buffer_select), 32'h08);
      repeat (2) tick();
      chk("swap_before_wrap", 32'(buffer_select), 32'h08);
      tick();
      chk("swap_wrap_strobe", 32'(pat_wrap), 32'd1);
      chk("swap_after_wrap", 32'(buffer_select), 32'h02);
      chk("swap_bufp", 32'(bufp), 32'h02);
      repeat (4) tick();
      stop = 1'b1; tick(); stop = 1'b0;
      drain();

      // Rejected write: field index out of range
      wr_buf = 3'd6; wr_field = 5'd22; wr_data = 8'hFF; wr_req = 1'b1;
      tick();
      chk("err_wr_ack", 32'(wr_ack), 32'd1);
      chk("err_wr_err", 32'(wr_err), 32'd1);
      chk("err_no_write", 32'(field_write), 32'd0);
      wr_req = 1'b0;
      tick();
      chk("err_ack_drop", 32'(wr_ack), 32'd0);
      chk("err_err_drop", 32'(wr_err), 32'd0);

      // Start with illegal length is ignored
      play_len = 5'd0; play_buf = 3'd3; start = 1'b1;
      tick(); start = 1'b0;
      chk("len0_busy", 32'(busy), 32'd0);
      tick();
      chk("len0_no_valid", 32'(pat_valid), 32'd0);

      // Start and stop together: stop wins
      play_len = 5'd5; start = 1'b1; stop = 1'b1;
      tick(); start = 1'b0; stop = 1'b0;
      chk("startstop_busy", 32'(busy), 32'd0);
      tick();
      chk("startstop_no_valid", 32'(pat_valid), 32'd0);

      // Swap while idle applies immediately
      swap_buf = 3'd5; swap_req = 1'b1;
      tick(); swap_req = 1'b0;
      chk("idle_swap_sel", 32'(buffer_select), 32'h20);
      chk("idle_swap_bufp", 32'(bufp), 32'h20);

      // Reset in the middle of a write drops field_write asynchronously
      wr_buf = 3'd5; wr_field = 5'd3; wr_data = 8'h77; wr_req = 1'b1;
      tick();
      chk("mid_wr_active", 32'(field_write), 32'd1);
      chk("mid_wr_fieldwp", 32'(fieldwp), 32'h8);
      #1 rst = 1'b1;
      #1;
      chk("async_rst_fw", 32'(field_write), 32'd0);
      chk("async_rst_ack", 32'(wr_ack), 32'd0);
      chk("async_rst_sel", 32'(buffer_select), 32'h01);
      chk("async_rst_bufp", 32'(bufp), 32'h01);
      wr_req = 1'b0;
      tick(); rst = 1'b0;
      tick();

      // Buffer 5 is untouched by the aborted write
      play_buf = 3'd5; play_len = 5'd4; start = 1'b1;
      for (int r = 0; r < 4; r++) push(8'(8'h50 + r), r == 3);
      tick(); start = 1'b0;
      chk("buf5_sel", 32'(buffer_select), 32'h20);
      repeat (3) tick();
      stop = 1'b1; tick(); stop = 1'b0;
      drain();
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
